cpu_run_monitor: RTL and testbench

Parametrised, synthesizable run controller and result dumper for the single-cycle CPU. It counts run cycles and detects end of program, either by a cycle budget or by the PC sitting in a self-loop. At the end event it freezes the CPU, snapshots NUM_CH watched values (register-file and data-memory words), then streams them out over a valid/ready port. It replaces a fixed end-count display bench with a reusable block usable on FPGA and in simulation.

---
 rtl/cpu_run_monitor_pkg.sv | 20 ++
 rtl/cpu_run_monitor_pc_loop_detector.sv | 60 ++++++
 rtl/cpu_run_monitor.sv | 126 ++++++++++++
 tb/tb_cpu_run_monitor.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_monitor_pkg.sv
// Shared types and constants for the CPU run monitor: controller states,
// end-cause encodings and a width helper for the dump index port.
package cpu_run_monitor_pkg;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      DUMP = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [1:0] CAUSE_NONE   = 2'd0;
   localparam logic [1:0] CAUSE_BUDGET = 2'd1;
   localparam logic [1:0] CAUSE_LOOP   = 2'd2;

   // A single-channel monitor still needs a 1-bit index port.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cpu_run_monitor_pc_loop_detector.sv
// Detects a CPU sitting in a self-loop: the PC repeats for HALT_WINDOW
// consecutive comparisons while enabled. HALT_WINDOW of 0 disables the hit.
module pc_loop_detector #(
   parameter int ADDR_W      = 32,
   parameter int HALT_WINDOW = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [ADDR_W-1:0] pc,
   output logic              loop_hit
);

   localparam int SW = (HALT_WINDOW > 1) ? $clog2(HALT_WINDOW) : 1;
   localparam logic [SW-1:0] HIT_AT  = SW'((HALT_WINDOW > 0) ? HALT_WINDOW - 1 : 0);
   localparam logic [SW-1:0] SAT_MAX = '1;

   logic [ADDR_W-1:0] last_pc_reg, last_pc_next;
   logic              last_vld_reg, last_vld_next;
   logic [SW-1:0]     stable_cnt_reg, stable_cnt_next;
   logic              pc_eq;

   assign pc_eq = last_vld_reg && (pc == last_pc_reg);

   always_comb begin
      last_pc_next    = last_pc_reg;
      last_vld_next   = last_vld_reg;
      stable_cnt_next = stable_cnt_reg;
      if (en) begin
         last_pc_next  = pc;
         last_vld_next = 1'b1;
         if (pc_eq)
            stable_cnt_next = (stable_cnt_reg == SAT_MAX) ? stable_cnt_reg
                                                          : stable_cnt_reg + SW'(1);
         else
            stable_cnt_next = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_pc_reg    <= '0;
         last_vld_reg   <= 1'b0;
         stable_cnt_reg <= '0;
      end else begin
         last_pc_reg    <= last_pc_next;
         last_vld_reg   <= last_vld_next;
         stable_cnt_reg <= stable_cnt_next;
      end
   end

   generate
      if (HALT_WINDOW == 0) begin : g_disabled
         assign loop_hit = 1'b0;
      end else begin : g_enabled
         assign loop_hit = en && pc_eq && (stable_cnt_reg == HIT_AT);
      end
   endgenerate

endmodule

// File: rtl/cpu_run_monitor.sv
// Run controller and result dumper: counts run cycles, ends the run on a
// cycle budget or PC self-loop, freezes the CPU and streams a snapshot out.
module cpu_run_monitor
   import cpu_run_monitor_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int NUM_CH      = 14,
   parameter int END_COUNT   = 600,
   parameter int HALT_WINDOW = 8,
   parameter int CNT_W       = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [ADDR_W-1:0]          pc_i,
   input  logic [NUM_CH*DATA_W-1:0]   ch_data_i,
   output logic                       cpu_halt_o,
   output logic                       dump_valid_o,
   input  logic                       dump_ready_i,
   output logic [DATA_W-1:0]          dump_data_o,
   output logic [idx_w(NUM_CH)-1:0]   dump_idx_o,
   output logic                       done_o,
   output logic [1:0]                 cause_o,
   output logic [CNT_W-1:0]           cycle_count_o
);

   localparam int IDX_W = idx_w(NUM_CH);
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_CH - 1);
   localparam logic [CNT_W-1:0] BUDGET_CNT = CNT_W'(END_COUNT - 1);

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic [1:0]         cause_reg, cause_next;
   logic [IDX_W-1:0]   idx_reg, idx_next;
   logic [DATA_W-1:0]  snap_reg [NUM_CH];
   logic [DATA_W-1:0]  ch_word  [NUM_CH];

   logic in_run;
   logic loop_hit;
   logic budget_hit;
   logic end_hit;

   assign in_run     = (state_reg == RUN);
   assign budget_hit = (cnt_reg == BUDGET_CNT);
   assign end_hit    = in_run && (budget_hit || loop_hit);

   pc_loop_detector #(
      .ADDR_W      (ADDR_W),
      .HALT_WINDOW (HALT_WINDOW)
   ) u_loop (
      .clk      (clk_i),
      .rst      (rst_i),
      .en       (in_run),
      .pc       (pc_i),
      .loop_hit (loop_hit)
   );

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         assign ch_word[gi] = ch_data_i[gi*DATA_W +: DATA_W];
      end
   endgenerate

   // Snapshot holds the pre-freeze channel values; only the end edge writes it.
   always_ff @(posedge clk_i) begin
      if (end_hit)
         snap_reg <= ch_word;
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      cause_next = cause_reg;
      idx_next   = idx_reg;
      case (state_reg)
         RUN: begin
            cnt_next = cnt_reg + CNT_W'(1);
            if (end_hit) begin
               // Budget takes priority when both end conditions coincide.
               cause_next = budget_hit ? CAUSE_BUDGET : CAUSE_LOOP;
               state_next = DUMP;
               idx_next   = '0;
            end
         end
         DUMP: begin
            if (dump_ready_i) begin
               if (idx_reg == LAST_IDX)
                  state_next = DONE;
               else
                  idx_next = idx_reg + IDX_W'(1);
            end
         end
         DONE: begin
            state_next = DONE;
         end
         default: begin
            state_next = RUN;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg <= RUN;
         cnt_reg   <= '0;
         cause_reg <= CAUSE_NONE;
         idx_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         cause_reg <= cause_next;
         idx_reg   <= idx_next;
      end
   end

   // Outputs decode registered state only, so ready never reaches valid.
   assign cpu_halt_o    = !in_run;
   assign dump_valid_o  = (state_reg == DUMP);
   assign done_o        = (state_reg == DONE);
   assign dump_data_o   = dump_valid_o ? snap_reg[idx_reg] : '0;
   assign dump_idx_o    = dump_valid_o ? idx_reg : '0;
   assign cause_o       = cause_reg;
   assign cycle_count_o = cnt_reg;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Randomised and directed bench for cpu_run_monitor; three instances with
// different budget/window settings share one stimulus and one reference model.
module tb_cpu_run_monitor;

   localparam int NI  = 3;
   localparam int NCH = 4;
   localparam int DW  = 32;
   localparam int AW  = 32;
   localparam int CW  = 16;
   localparam int IW  = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [AW-1:0]     pc;
   logic [NCH*DW-1:0] ch;
   logic              rdy;

   logic              halt  [NI];
   logic              valid [NI];
   logic              done  [NI];
   logic [DW-1:0]     data  [NI];
   logic [IW-1:0]     didx  [NI];
   logic [1:0]        cause [NI];
   logic [CW-1:0]     cnt   [NI];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   cpu_run_monitor #(.ADDR_W(AW), .DATA_W(DW), .NUM_CH(NCH), .END_COUNT(20),
                     .HALT_WINDOW(3), .CNT_W(CW)) u0 (
      .clk_i(clk), .rst_i(rst), .pc_i(pc), .ch_data_i(ch),
      .cpu_halt_o(halt[0]), .dump_valid_o(valid[0]), .dump_ready_i(rdy),
      .dump_data_o(data[0]), .dump_idx_o(didx[0]), .done_o(done[0]),
      .cause_o(cause[0]), .cycle_count_o(cnt[0]));

   cpu_run_monitor #(.ADDR_W(AW), .DATA_W(DW), .NUM_CH(NCH), .END_COUNT(4),
                     .HALT_WINDOW(3), .CNT_W(CW)) u1 (
      .clk_i(clk), .rst_i(rst), .pc_i(pc), .ch_data_i(ch),
      .cpu_halt_o(halt[1]), .dump_valid_o(valid[1]), .dump_ready_i(rdy),
      .dump_data_o(data[1]), .dump_idx_o(didx[1]), .done_o(done[1]),
      .cause_o(cause[1]), .cycle_count_o(cnt[1]));

   cpu_run_monitor #(.ADDR_W(AW), .DATA_W(DW), .NUM_CH(NCH), .END_COUNT(20),
                     .HALT_WINDOW(0), .CNT_W(CW)) u2 (
      .clk_i(clk), .rst_i(rst), .pc_i(pc), .ch_data_i(ch),
      .cpu_halt_o(halt[2]), .dump_valid_o(valid[2]), .dump_ready_i(rdy),
      .dump_data_o(data[2]), .dump_idx_o(didx[2]), .done_o(done[2]),
      .cause_o(cause[2]), .cycle_count_o(cnt[2]));

   // Reference model: phase 0 running, 1 dumping, 2 finished.
   int            m_phase  [NI];
   int            m_cnt    [NI];
   int            m_cause  [NI];
   int            m_idx    [NI];
   int            m_runlen [NI];
   logic [AW-1:0] m_prev   [NI];
   logic [DW-1:0] m_snap   [NI][NCH];
   bit            m_init = 0;

   logic [DW-1:0] acc_q    [$];
   logic [IW-1:0] accidx_q [$];

   function automatic int ec_of(input int m);
      return (m == 1) ? 4 : 20;
   endfunction

   function automatic int hw_of(input int m);
      return (m == 2) ? 0 : 3;
   endfunction

   function automatic logic [NCH*DW-1:0] pack4(input logic [DW-1:0] a0, a1, a2, a3);
      return {a3, a2, a1, a0};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Advance the model across one rising edge with the inputs now applied.
   task automatic model_step(input logic r, input logic [AW-1:0] p,
                             input logic [NCH*DW-1:0] c, input logic rd);
      bit budget, loop;
      for (int m = 0; m < NI; m++) begin
         if (r) begin
            m_phase[m] = 0; m_cnt[m] = 0; m_cause[m] = 0;
            m_idx[m] = 0; m_runlen[m] = 0;
         end else if (m_phase[m] == 0) begin
            if (m_runlen[m] > 0 && p == m_prev[m]) m_runlen[m]++;
            else m_runlen[m] = 1;
            m_prev[m] = p;
            budget = (m_cnt[m] == ec_of(m) - 1);
            loop   = (hw_of(m) != 0) && (m_runlen[m] >= hw_of(m) + 1);
            m_cnt[m]++;
            if (budget || loop) begin
               for (int k = 0; k < NCH; k++) m_snap[m][k] = c[k*DW +: DW];
               m_cause[m] = budget ? 1 : 2;
               m_phase[m] = 1;
               m_idx[m]   = 0;
            end
         end else if (m_phase[m] == 1) begin
            if (rd) begin
               if (m_idx[m] == NCH - 1) m_phase[m] = 2;
               else m_idx[m]++;
            end
         end
      end
      if (r) m_init = 1;
   endtask

   task automatic compare();
      logic [DW-1:0] exp_data;
      logic [IW-1:0] exp_idx;
      for (int m = 0; m < NI; m++) begin
         exp_data = (m_phase[m] == 1) ? m_snap[m][m_idx[m]] : '0;
         exp_idx  = (m_phase[m] == 1) ? IW'(m_idx[m]) : '0;
         chk($sformatf("u%0d_halt", m),  64'(halt[m]),  64'(m_phase[m] != 0));
         chk($sformatf("u%0d_valid", m), 64'(valid[m]), 64'(m_phase[m] == 1));
         chk($sformatf("u%0d_done", m),  64'(done[m]),  64'(m_phase[m] == 2));
         chk($sformatf("u%0d_cause", m), 64'(cause[m]), 64'(m_cause[m]));
         chk($sformatf("u%0d_count", m), 64'(cnt[m]),   64'(m_cnt[m]));
         chk($sformatf("u%0d_idx", m),   64'(didx[m]),  64'(exp_idx));
         chk($sformatf("u%0d_data", m),  64'(data[m]),  64'(exp_data));
      end
   endtask

   task automatic step(input logic r, input logic [AW-1:0] p,
                       input logic [NCH*DW-1:0] c, input logic rd);
      rst = r; pc = p; ch = c; rdy = rd;
      if (!r && valid[0] === 1'b1 && rd) begin
         acc_q.push_back(data[0]);
         accidx_q.push_back(didx[0]);
         $display("accept u0 idx=%0d data=%0h", didx[0], data[0]);
      end
      model_step(r, p, c, rd);
      @(negedge clk);
      if (m_init) compare();
   endtask

   task automatic do_reset();
      step(1'b1, '0, '0, 1'b0);
      step(1'b1, '0, '0, 1'b0);
      acc_q.delete();
      accidx_q.delete();
   endtask

   task automatic pin_words(input string nm);
      chk({nm, "_nwords"}, 64'(acc_q.size()), 64'(NCH));
      for (int i = 0; i < NCH && i < acc_q.size(); i++) begin
         chk($sformatf("%s_word%0d", nm, i), 64'(acc_q[i]), 64'(10 * (i + 1)));
         chk($sformatf("%s_widx%0d", nm, i), 64'(accidx_q[i]), 64'(i));
      end
   endtask

   logic [NCH*DW-1:0] ch1;
   logic [NCH*DW-1:0] cr;
   logic [DW-1:0]     ch0_at_end;
   logic [AW-1:0]     rp;
   logic              bp_pat [7];
   int                j;

   initial begin
      ch1 = pack4(32'd10, 32'd20, 32'd30, 32'd40);
      bp_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      rst = 1'b1; pc = '0; ch = '0; rdy = 1'b0;

      // Budget end with incrementing PC.
      do_reset();
      chk("reset_valid", 64'(valid[0]), 64'd0);
      chk("reset_count", 64'(cnt[0]), 64'd0);
      for (int t = 0; t < 40; t++) step(1'b0, AW'(t * 4), ch1, 1'b1);
      chk("budget_cause", 64'(cause[0]), 64'd1);
      chk("budget_count", 64'(cnt[0]), 64'd20);
      pin_words("budget");
      for (int m = 0; m < NI; m++) chk($sformatf("budget_done_u%0d", m), 64'(done[m]), 64'd1);

      // Loop end: 0,4,8 then held; end edge on the third equal comparison.
      do_reset();
      ch0_at_end = '0;
      for (int t = 0; t < 40; t++) begin
         cr = {$urandom, $urandom, $urandom, $urandom};
         if (t == 5) ch0_at_end = cr[DW-1:0];
         step(1'b0, (t < 2) ? AW'(t * 4) : AW'(8), cr, 1'b1);
      end
      chk("loop_cause", 64'(cause[0]), 64'd2);
      chk("loop_count", 64'(cnt[0]), 64'd6);
      chk("loop_snap0", 64'(acc_q.size() > 0 ? acc_q[0] : '0), 64'(ch0_at_end));
      chk("loop_model_count", 64'(m_cnt[0]), 64'd6);

      // Backpressure pattern applied once dumping starts.
      do_reset();
      j = 0;
      for (int t = 0; t < 40; t++) begin
         if (m_phase[0] == 1 && j < 7) begin
            step(1'b0, AW'(t * 4), ch1, bp_pat[j]);
            j++;
         end else begin
            step(1'b0, AW'(t * 4), ch1, 1'b1);
         end
      end
      pin_words("bp");

      // Constant PC: u0 loop, u1 loop and budget coincide, u2 loop disabled.
      do_reset();
      for (int t = 0; t < 40; t++) step(1'b0, AW'(32'h100), ch1, 1'b1);
      chk("const_u0_cause", 64'(cause[0]), 64'd2);
      chk("const_u0_count", 64'(cnt[0]), 64'd4);
      chk("coinc_u1_cause", 64'(cause[1]), 64'd1);
      chk("coinc_u1_count", 64'(cnt[1]), 64'd4);
      chk("nolp_u2_cause", 64'(cause[2]), 64'd1);
      chk("nolp_u2_count", 64'(cnt[2]), 64'd20);
      chk("const_model_cause", 64'(m_cause[0]), 64'd2);

      // Reset after two accepted words, then a full rerun.
      do_reset();
      for (int t = 0; t < 40 && acc_q.size() < 2; t++) step(1'b0, AW'(t * 4), ch1, 1'b1);
      chk("midrst_accepts", 64'(acc_q.size()), 64'd2);
      step(1'b1, '0, ch1, 1'b1);
      chk("midrst_valid", 64'(valid[0]), 64'd0);
      chk("midrst_halt", 64'(halt[0]), 64'd0);
      chk("midrst_done", 64'(done[0]), 64'd0);
      chk("midrst_count", 64'(cnt[0]), 64'd0);
      acc_q.delete();
      accidx_q.delete();
      for (int t = 0; t < 40; t++) step(1'b0, AW'(t * 4), ch1, 1'b1);
      pin_words("rerun");

      // Random runs with sticky PCs, random ready and occasional resets.
      for (int run = 0; run < 8; run++) begin
         do_reset();
         rp = '0;
         for (int t = 0; t < 50; t++) begin
            if ($urandom_range(0, 9) < 3) rp = AW'($urandom_range(0, 3) * 4);
            cr = {$urandom, $urandom, $urandom, $urandom};
            step(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0, rp, cr,
                 1'($urandom_range(0, 1)));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
